// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: issues one instruction-memory request at a
// time, tracks the in-flight PC, and presents fetched instructions to decode
// through a registered output stage backed by a one-entry skid register.
// Redirects (pcsrc) flush the output and skid, and kill any response that is
// still outstanding so the stale instruction never reaches decode.
// Optional build macro FETCH_PERF_EN adds perf_fetch / perf_kill counters.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        pcsrc,
  input  logic [31:0] pctarget,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc4_d,
  output logic        valid_d,
`ifdef FETCH_PERF_EN
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_kill,
`endif
  input  logic        ready_d
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Address increment wraps naturally at 2^32.
  function automatic logic [31:0] pc_inc(input logic [31:0] a);
    return a + 32'd4;
  endfunction

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        kill, kill_nxt;
  logic        skid_vld, skid_vld_nxt;
  logic        valid_nxt;

  logic [31:0] inflight_pc;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;

  logic        cap_inflight;
  logic        skid_ld;
  logic        out_ld;
  logic        out_sel_skid;
  logic [31:0] ld_pc;

  assign imem_req  = (state == REQ);
  assign imem_addr = pc;
  assign ld_pc     = out_sel_skid ? skid_pc : inflight_pc;

  // Next-state, PC, kill and output-register control.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    skid_vld_nxt = skid_vld;
    valid_nxt    = valid_d;
    cap_inflight = 1'b0;
    skid_ld      = 1'b0;
    out_ld       = 1'b0;
    out_sel_skid = 1'b0;

    if (valid_d && ready_d) begin
      valid_nxt = 1'b0;
    end

    if (pcsrc) begin
      // Redirect wins over everything, including a response arriving now.
      pc_nxt       = pctarget;
      valid_nxt    = 1'b0;
      skid_vld_nxt = 1'b0;
      if ((state == WAIT && !imem_rvalid) || (state == REQ && imem_gnt)) begin
        // A response is still owed by memory: wait for it and drop it.
        kill_nxt  = 1'b1;
        state_nxt = WAIT;
      end else begin
        kill_nxt  = 1'b0;
        state_nxt = REQ;
      end
    end else begin
      case (state)
        IDLE: state_nxt = REQ;
        REQ: begin
          if (imem_gnt) begin
            cap_inflight = 1'b1;
            state_nxt    = WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill_nxt  = 1'b0;
              state_nxt = REQ;
            end else if (!valid_d || ready_d) begin
              out_ld    = 1'b1;
              valid_nxt = 1'b1;
              pc_nxt    = pc_inc(pc);
              state_nxt = REQ;
            end else begin
              skid_ld      = 1'b1;
              skid_vld_nxt = 1'b1;
              state_nxt    = HOLD;
            end
          end
        end
        HOLD: begin
          if (ready_d && skid_vld) begin
            out_ld       = 1'b1;
            out_sel_skid = 1'b1;
            valid_nxt    = 1'b1;
            skid_vld_nxt = 1'b0;
            pc_nxt       = pc_inc(pc);
            state_nxt    = REQ;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Control state: FSM, PC, kill flag and skid occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_VECTOR;
      kill     <= 1'b0;
      skid_vld <= 1'b0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      kill     <= kill_nxt;
      skid_vld <= skid_vld_nxt;
    end
  end

  // In-flight PC and skid payload; qualified by FSM state and skid_vld.
  always_ff @(posedge clk) begin
    if (cap_inflight) begin
      inflight_pc <= pc;
    end
    if (skid_ld) begin
      skid_instr <= imem_rdata;
      skid_pc    <= inflight_pc;
    end
  end

  // Decode-facing output register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_d <= 1'b0;
      instr_d <= 32'h0;
      pc_d    <= 32'h0;
      pc4_d   <= 32'h0;
    end else begin
      valid_d <= valid_nxt;
      if (out_ld) begin
        instr_d <= out_sel_skid ? skid_instr : imem_rdata;
        pc_d    <= ld_pc;
        pc4_d   <= pc_inc(ld_pc);
      end
    end
  end

`ifdef FETCH_PERF_EN
  logic drop;
  assign drop = (state == WAIT) && imem_rvalid && (kill || pcsrc);

  // Performance counters: output-register loads and discarded responses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetch <= 32'h0;
      perf_kill  <= 32'h0;
    end else begin
      if (out_ld) perf_fetch <= perf_fetch + 32'd1;
      if (drop)   perf_kill  <= perf_kill + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed, table-driven bench for fetch_ctrl plus hand sequences for the
// asynchronous reset and redirect corner cases. A second instance with a
// reset vector at the top of the address space shares the stimulus.
module tb_fetch_ctrl;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;

  localparam logic [31:0] STALE = 32'hDEAD_0000;
  localparam logic [31:0] BAD   = 32'hBAD0_BAD0;
  localparam logic [31:0] I0    = 32'h1111_0000;
  localparam logic [31:0] I1    = 32'h2222_0004;
  localparam logic [31:0] I2    = 32'h3333_0008;
  localparam logic [31:0] I3    = 32'h4444_000C;
  localparam logic [31:0] I4    = 32'h5555_0100;
  localparam logic [31:0] I5    = 32'h6666_0104;
  localparam logic [31:0] I6    = 32'h7777_0200;
  localparam logic [31:0] I7    = 32'h8888_0400;
  localparam logic [31:0] I8    = 32'h9999_0500;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_gnt, imem_rvalid, pcsrc, ready_d;
  logic [31:0] imem_rdata, pctarget;

  logic        imem_req, valid_d;
  logic [31:0] imem_addr, instr_d, pc_d, pc4_d;
  logic        v2_req, v2_valid;
  logic [31:0] v2_addr, v2_instr, v2_pc_d, v2_pc4_d;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetch, perf_kill, v2_perf_fetch, v2_perf_kill;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcsrc(pcsrc), .pctarget(pctarget),
    .instr_d(instr_d), .pc_d(pc_d), .pc4_d(pc4_d), .valid_d(valid_d),
`ifdef FETCH_PERF_EN
    .perf_fetch(perf_fetch), .perf_kill(perf_kill),
`endif
    .ready_d(ready_d)
  );

  fetch_ctrl #(.RESET_VECTOR(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .rst(rst),
    .imem_req(v2_req), .imem_addr(v2_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pcsrc(pcsrc), .pctarget(pctarget),
    .instr_d(v2_instr), .pc_d(v2_pc_d), .pc4_d(v2_pc4_d), .valid_d(v2_valid),
`ifdef FETCH_PERF_EN
    .perf_fetch(v2_perf_fetch), .perf_kill(v2_perf_kill),
`endif
    .ready_d(ready_d)
  );

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        pcsrc;
    logic [31:0] tgt;
    logic        ready;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pcd;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic er, input logic [31:0] ea,
                         input logic ev, input logic [31:0] ei,
                         input logic [31:0] ep, input logic [31:0] e4);
    chk({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, er});
    chk({tag, " imem_addr"}, imem_addr, ea);
    chk({tag, " valid_d"}, {31'd0, valid_d}, {31'd0, ev});
    chk({tag, " instr_d"}, instr_d, ei);
    chk({tag, " pc_d"}, pc_d, ep);
    chk({tag, " pc4_d"}, pc4_d, e4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //          gnt rv rdata  ps tgt           rdy  req addr          vld instr pc_d          pc4_d
    tbl[0]  = '{H, H, STALE, L, 32'h0,   H,   L, 32'h0,   L, 32'h0, 32'h0,   32'h0};
    tbl[1]  = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h0,   L, 32'h0, 32'h0,   32'h0};
    tbl[2]  = '{H, H, I0,    L, 32'h0,   H,   L, 32'h0,   L, 32'h0, 32'h0,   32'h0};
    tbl[3]  = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h4,   H, I0,    32'h0,   32'h4};
    tbl[4]  = '{H, H, I1,    L, 32'h0,   H,   L, 32'h4,   L, I0,    32'h0,   32'h4};
    tbl[5]  = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h8,   H, I1,    32'h4,   32'h8};
    tbl[6]  = '{H, H, I2,    L, 32'h0,   H,   L, 32'h8,   L, I1,    32'h4,   32'h8};
    tbl[7]  = '{H, L, 32'h0, L, 32'h0,   L,   H, 32'hC,   H, I2,    32'h8,   32'hC};
    tbl[8]  = '{H, H, I3,    L, 32'h0,   L,   L, 32'hC,   H, I2,    32'h8,   32'hC};
    tbl[9]  = '{H, H, BAD,   L, 32'h0,   L,   L, 32'hC,   H, I2,    32'h8,   32'hC};
    tbl[10] = '{H, L, 32'h0, L, 32'h0,   L,   L, 32'hC,   H, I2,    32'h8,   32'hC};
    tbl[11] = '{H, L, 32'h0, L, 32'h0,   L,   L, 32'hC,   H, I2,    32'h8,   32'hC};
    tbl[12] = '{H, L, 32'h0, L, 32'h0,   H,   L, 32'hC,   H, I2,    32'h8,   32'hC};
    tbl[13] = '{L, L, 32'h0, L, 32'h0,   H,   H, 32'h10,  H, I3,    32'hC,   32'h10};
    tbl[14] = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h10,  L, I3,    32'hC,   32'h10};
    tbl[15] = '{H, L, 32'h0, H, 32'h100, H,   L, 32'h10,  L, I3,    32'hC,   32'h10};
    tbl[16] = '{H, L, 32'h0, L, 32'h0,   H,   L, 32'h100, L, I3,    32'hC,   32'h10};
    tbl[17] = '{H, H, BAD,   L, 32'h0,   H,   L, 32'h100, L, I3,    32'hC,   32'h10};
    tbl[18] = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h100, L, I3,    32'hC,   32'h10};
    tbl[19] = '{H, H, I4,    L, 32'h0,   L,   L, 32'h100, L, I3,    32'hC,   32'h10};
    tbl[20] = '{H, L, 32'h0, L, 32'h0,   L,   H, 32'h104, H, I4,    32'h100, 32'h104};
    tbl[21] = '{H, H, I5,    H, 32'h200, L,   L, 32'h104, H, I4,    32'h100, 32'h104};
    tbl[22] = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h200, L, I4,    32'h100, 32'h104};
    tbl[23] = '{H, H, I6,    L, 32'h0,   H,   L, 32'h200, L, I4,    32'h100, 32'h104};
    tbl[24] = '{L, L, 32'h0, L, 32'h0,   H,   H, 32'h204, H, I6,    32'h200, 32'h204};
    tbl[25] = '{H, L, 32'h0, H, 32'h300, H,   H, 32'h204, L, I6,    32'h200, 32'h204};
    tbl[26] = '{H, L, 32'h0, H, 32'h400, H,   L, 32'h300, L, I6,    32'h200, 32'h204};
    tbl[27] = '{H, H, BAD,   L, 32'h0,   H,   L, 32'h400, L, I6,    32'h200, 32'h204};
    tbl[28] = '{H, L, 32'h0, L, 32'h0,   H,   H, 32'h400, L, I6,    32'h200, 32'h204};
    tbl[29] = '{H, H, I7,    L, 32'h0,   H,   L, 32'h400, L, I6,    32'h200, 32'h204};
    tbl[30] = '{L, L, 32'h0, L, 32'h0,   H,   H, 32'h404, H, I7,    32'h400, 32'h404};
    tbl[31] = '{L, L, 32'h0, L, 32'h0,   H,   H, 32'h404, L, I7,    32'h400, 32'h404};

    rst = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    pcsrc = 1'b0; pctarget = 32'h0; ready_d = 1'b0;
    repeat (2) step();

    chk_out("reset", L, 32'h0, L, 32'h0, 32'h0, 32'h0);
    chk("reset v2 addr", v2_addr, 32'hFFFF_FFFC);

    rst = 1'b1;
    for (int i = 0; i < 32; i++) begin
      imem_gnt    = tbl[i].gnt;
      imem_rvalid = tbl[i].rvalid;
      imem_rdata  = tbl[i].rdata;
      pcsrc       = tbl[i].pcsrc;
      pctarget    = tbl[i].tgt;
      ready_d     = tbl[i].ready;
      chk_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_addr, tbl[i].e_valid,
              tbl[i].e_instr, tbl[i].e_pcd, tbl[i].e_pc4);
      if (i == 1) begin
        chk("v2 first addr", v2_addr, 32'hFFFF_FFFC);
        chk("v2 first req", {31'd0, v2_req}, 32'd1);
      end
      if (i == 3) begin
        chk("v2 pc_d", v2_pc_d, 32'hFFFF_FFFC);
        chk("v2 pc4_d wrap", v2_pc4_d, 32'h0);
        chk("v2 next addr", v2_addr, 32'h0);
        chk("v2 instr_d", v2_instr, I0);
        chk("v2 valid_d", {31'd0, v2_valid}, 32'd1);
      end
      step();
    end

    // Reset asserted while a response is outstanding.
    imem_gnt = 1'b1; imem_rvalid = 1'b0; pcsrc = 1'b0; ready_d = 1'b1;
    step();
    chk("pre-reset WAIT req", {31'd0, imem_req}, 32'd0);
    imem_gnt = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk_out("async reset", L, 32'h0, L, 32'h0, 32'h0, 32'h0);
    chk("async reset v2 addr", v2_addr, 32'hFFFF_FFFC);

    // Stale response while in reset and before the first grant.
    imem_rvalid = 1'b1; imem_rdata = STALE;
    step();
    rst = 1'b1;
    chk("post-reset IDLE req", {31'd0, imem_req}, 32'd0);
    step();
    chk_out("post-reset REQ", H, 32'h0, L, 32'h0, 32'h0, 32'h0);
    step();
    chk_out("stale ignored", H, 32'h0, L, 32'h0, 32'h0, 32'h0);

    // Grant, redirect while waiting, then the killed response arrives.
    imem_rvalid = 1'b0; imem_gnt = 1'b1;
    step();
    pcsrc = 1'b1; pctarget = 32'h500;
    step();
    pcsrc = 1'b0;
    chk("kill WAIT req", {31'd0, imem_req}, 32'd0);
    chk("kill WAIT addr", imem_addr, 32'h500);
    imem_rvalid = 1'b1; imem_rdata = BAD;
    step();
    imem_rvalid = 1'b0;
    chk_out("after kill", H, 32'h500, L, 32'h0, 32'h0, 32'h0);
`ifdef FETCH_PERF_EN
    chk("perf_kill", perf_kill, 32'd1);
    chk("perf_fetch", perf_fetch, 32'd0);
    chk("v2 perf_kill", v2_perf_kill, 32'd1);
    chk("v2 perf_fetch", v2_perf_fetch, 32'd0);
`endif
    step();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = I8;
    step();
    imem_rvalid = 1'b0;
    chk_out("redirect fetch", H, 32'h504, H, I8, 32'h500, 32'h504);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-004 SHALL have port imem_req, output, 1 bit: instruction-memory request valid.
REQ-005 SHALL have port imem_addr, output, 32 bits: request address, equal to the PC register.
REQ-006 SHALL have port imem_gnt, input, 1 bit: memory accepts the request this cycle.
REQ-007 SHALL have port imem_rvalid, input, 1 bit: response valid; no backpressure.
REQ-008 SHALL have port imem_rdata, input, 32 bits: response instruction.
REQ-009 SHALL have port pcsrc, input, 1 bit: taken branch/jump redirect pulse from execute.
REQ-010 SHALL have port pctarget, input, 32 bits: redirect address, sampled when pcsrc=1.
REQ-011 SHALL have port instr_d, output, 32 bits: registered instruction to decode.
REQ-012 SHALL have port pc_d, output, 32 bits: registered PC of instr_d.
REQ-013 SHALL have port pc4_d, output, 32 bits: pc_d+4, modulo 2^32.
REQ-014 SHALL have port valid_d, output, 1 bit: instr_d/pc_d/pc4_d hold a live instruction.
REQ-015 SHALL have port ready_d, input, 1 bit: decode consumes the output this cycle when valid_d=1.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, HOLD.
REQ-017 IDLE SHALL last exactly one cycle after reset release and then go to REQ.
REQ-018 In REQ, imem_req SHALL be 1; imem_gnt=1 SHALL capture the in-flight PC and go to WAIT; imem_gnt=0 SHALL stay in REQ.
REQ-019 In WAIT, imem_req SHALL be 0; at most one request SHALL be outstanding.
REQ-020 On a live imem_rvalid with the output register empty or consumed this cycle (valid_d=0 or ready_d=1), the output register SHALL load instr_d=imem_rdata, pc_d=the in-flight PC, pc4_d=the in-flight PC+4, valid_d=1, and PC SHALL advance by 4 with the FSM going to REQ.
REQ-021 On a live imem_rvalid with valid_d=1 and ready_d=0, the response SHALL be stored in a one-entry skid register and the FSM SHALL go to HOLD.
REQ-022 In HOLD, imem_req SHALL be 0; when ready_d=1, the skid entry SHALL move to the output register on the next edge, PC SHALL advance by 4, and the FSM SHALL go to REQ.
REQ-023 valid_d SHALL clear on consumption (valid_d=1, ready_d=1) when no new instruction is loaded in that cycle.
REQ-024 pcsrc=1 in any state SHALL, on the next edge, load PC=pctarget, clear valid_d, clear the skid entry, and go to REQ.
REQ-025 pcsrc=1 in WAIT, or in REQ with imem_gnt=1, SHALL set a kill flag; the next imem_rvalid SHALL be discarded, with no output or PC update, and the flag SHALL clear.
REQ-026 While the kill flag is set, the FSM SHALL stay in WAIT and SHALL NOT issue a request until the discarded response arrives; it SHALL then go to REQ with PC=target.
REQ-027 pcsrc=1 coinciding with a live imem_rvalid SHALL take priority: the response SHALL be discarded.
REQ-028 pcsrc=1 with kill already set SHALL update PC to the newest pctarget and keep a single kill.
REQ-029 imem_rvalid in IDLE, REQ or HOLD SHALL be ignored.
REQ-030 PC+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).

Reset
REQ-031 rst=0 SHALL immediately set FSM=IDLE, PC=RESET_VECTOR, kill=0, skid empty, valid_d=0, instr_d=pc_d=pc4_d=0, imem_req=0.
REQ-032 Reset asserted mid-transaction SHALL abandon any outstanding response; a stale imem_rvalid after reset release and before the first grant SHALL be ignored.

Configuration
REQ-033 With macro FETCH_PERF_EN defined, the block SHALL add outputs perf_fetch (32 bits, counts output-register loads) and perf_kill (32 bits, counts discarded responses), both reset to 0 and wrapping at 2^32; without the macro, these ports and counters SHALL be absent and behaviour otherwise identical.

Verification
REQ-034 Reset release, imem_gnt=1 every cycle, imem_rvalid one cycle after each grant, ready_d=1 -> pc_d = 0x0, 0x4, 0x8; valid_d=1 every other cycle.
REQ-035 valid_d=1 with ready_d=0 for 5 cycles while a response arrives -> HOLD entered; no imem_req; the held instruction appears exactly once after ready_d=1; no instruction is lost or duplicated.
REQ-036 pcsrc=1, pctarget=0x100 in WAIT -> the next response is dropped; the next imem_addr=0x100; the instruction at 0x100 is delivered with pc4_d=0x104.
REQ-037 pcsrc=1 in the same cycle as imem_rvalid, with valid_d=1 and ready_d=0 -> valid_d=0 next cycle; the skid stays empty; fetch restarts at pctarget.
REQ-038 RESET_VECTOR=32'hFFFF_FFFC -> first pc_d=0xFFFF_FFFC with pc4_d=0x0; the next fetch address is 0x0.
REQ-039 rst pulsed low while in WAIT -> all outputs are 0 asynchronously; with FETCH_PERF_EN, perf_kill=1 after one killed redirect.
